// File: rtl/loader_pkg.sv
// Shared definitions for the CPU program loader: state encoding, default image geometry
// and state-class helpers.
package loader_pkg;

  localparam int LOADER_PROG_BYTES = 16;
  localparam int LOADER_ADDR_W     = $clog2(LOADER_PROG_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_SEND,
    ST_GAP,
    ST_WAIT_DONE,
    ST_DONE,
    ST_ERROR
  } state_t;

  // States in which the loader owns the CPU handshake.
  function automatic logic is_active(input state_t s);
    return s inside {ST_ARM, ST_SEND, ST_GAP, ST_WAIT_DONE};
  endfunction

  // States from which a start request is honoured.
  function automatic logic can_start(input state_t s);
    return s inside {ST_IDLE, ST_DONE, ST_ERROR};
  endfunction

endpackage

// File: rtl/prog_image_mem.sv
// Program image register file: synchronous write from the host, asynchronous read
// addressed by the loader. Contents are deliberately not reset.
module prog_image_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/cpu_program_loader.sv
// Transmit side of the CPU program-load handshake: paces image bytes onto the CPU on ready/done_load.
// Optional handshake watchdog enabled by defining LOADER_TIMEOUT_EN.
//
//   state     | meaning
//   IDLE      | no load since reset
//   ARM       | byte presented, waiting for cpu_ready high
//   SEND      | CPU sampling, waiting for cpu_ready low
//   GAP       | fetch next byte into prog_data
//   WAIT_DONE | all bytes handed over, waiting for cpu_done_load
//   DONE      | load completed
//   ERROR     | early done_load or watchdog expiry
module cpu_program_loader
  import loader_pkg::*;
#(
  parameter int PROG_BYTES     = LOADER_PROG_BYTES,
  parameter int ADDR_W         = LOADER_ADDR_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_data,
  input  logic              start,
  input  logic              cpu_ready,
  input  logic              cpu_done_load,
  output logic              programming,
  output logic [7:0]        prog_data,
  output logic              busy,
  output logic              load_done,
  output logic              error,
  output logic [ADDR_W:0]   byte_cnt
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(PROG_BYTES);
  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(PROG_BYTES - 1);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("cpu_program_loader: TIMEOUT_CYCLES must be at least 2");
  end

  state_t            state, state_next;
  logic              cnt_inc;
  logic              wd_expired;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        first_byte;

  prog_image_mem #(
    .DEPTH  (PROG_BYTES),
    .ADDR_W (ADDR_W)
  ) u_image (
    .clk     (clk),
    .we      (host_we && !busy),
    .wr_addr (host_addr),
    .wr_data (host_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  assign busy        = is_active(state);
  assign programming = busy;
  assign load_done   = (state == ST_DONE);
  assign error       = (state == ST_ERROR);

  // Outside a load byte_cnt may sit at PROG_BYTES; the first byte is always image[0].
  assign rd_addr = busy ? byte_cnt[ADDR_W-1:0] : '0;

  // A host write coinciding with start lands this edge, so forward it into byte 0.
  assign first_byte = (host_we && host_addr == '0) ? host_data : rd_data;

  always_comb begin
    state_next = state;
    cnt_inc    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) state_next = ST_ARM;
      end
      ST_ARM: begin
        if (cpu_done_load)  state_next = ST_ERROR;
        else if (cpu_ready) state_next = ST_SEND;
      end
      ST_SEND: begin
        if (!cpu_ready && byte_cnt == LAST_CNT) begin
          cnt_inc    = 1'b1;
          state_next = cpu_done_load ? ST_DONE : ST_WAIT_DONE;
        end else if (cpu_done_load) begin
          state_next = ST_ERROR;
        end else if (!cpu_ready) begin
          cnt_inc    = 1'b1;
          state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        state_next = cpu_done_load ? ST_ERROR : ST_ARM;
      end
      ST_WAIT_DONE: begin
        if (cpu_done_load) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (wd_expired && state_next == state &&
        state inside {ST_ARM, ST_SEND, ST_WAIT_DONE}) begin
      state_next = ST_ERROR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      byte_cnt  <= '0;
      prog_data <= '0;
    end else begin
      state <= state_next;
      if (can_start(state) && start) begin
        byte_cnt  <= '0;
        prog_data <= first_byte;
      end else begin
        if (cnt_inc && byte_cnt != FULL_CNT) byte_cnt <= byte_cnt + 1'b1;
        if (state == ST_GAP) prog_data <= rd_data;
      end
    end
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

  logic [WD_W-1:0] wd_cnt;

  // Reloads on entry to every state so it measures time spent in the current state only.
  always_ff @(posedge clk) begin
    if (rst || state_next != state) wd_cnt <= WD_LOAD;
    else if (wd_cnt != '0)          wd_cnt <= wd_cnt - 1'b1;
  end

  assign wd_expired = (wd_cnt == '0);
`else
  assign wd_expired = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_program_loader.sv
// Self-checking bench for cpu_program_loader: table of load scenarios driven through a CPU
// handshake model, with a byte scoreboard, plus hand sequences for reset, idle and watchdog cases.
module tb_cpu_program_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_we;
  logic [3:0] host_addr;
  logic [7:0] host_data;
  logic       start;
  logic       cpu_ready;
  logic       cpu_done_load;
  logic       programming;
  logic [7:0] prog_data;
  logic       busy;
  logic       load_done;
  logic       error;
  logic [4:0] byte_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] img [16];
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    int         done_after;  // byte index at which done_load is raised early (16 = normal)
    bit         coincide;    // done_load rises with the last ready fall
    int         rst_at;      // byte index during which rst is pulsed (16 = never)
    bit         wr_busy;     // host writes 0xAA to addr 3 while busy
    bit         wr_at_start; // host writes 0x5A to addr 0 in the start cycle
    bit         exp_done;
    bit         exp_err;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [9];

  cpu_program_loader #(
    .PROG_BYTES     (16),
    .ADDR_W         (4),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_data     (host_data),
    .start         (start),
    .cpu_ready     (cpu_ready),
    .cpu_done_load (cpu_done_load),
    .programming   (programming),
    .prog_data     (prog_data),
    .busy          (busy),
    .load_done     (load_done),
    .error         (error),
    .byte_cnt      (byte_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic write_image(input logic [7:0] base, input logic [7:0] step);
    for (int i = 0; i < 16; i++) begin
      img[i] = 8'(base + step * i);
      @(negedge clk);
      host_we   = 1'b1;
      host_addr = 4'(i);
      host_data = img[i];
    end
    @(negedge clk);
    host_we = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int  n;
    bit  aborted;
    bit  done_sent;
    logic [7:0] exp_b;
    aborted   = 1'b0;
    done_sent = 1'b0;
    write_image(v.base, v.step);
    if (v.wr_at_start) img[0] = 8'h5A;
    n = v.done_after;
    if (v.rst_at + 1 < n) n = v.rst_at + 1;
    for (int i = 0; i < n; i++) exp_q.push_back(img[i]);

    @(negedge clk);
    start = 1'b1;
    if (v.wr_at_start) begin
      host_we   = 1'b1;
      host_addr = 4'd0;
      host_data = 8'h5A;
    end
    @(negedge clk);
    start   = 1'b0;
    host_we = 1'b0;
    if (v.wr_busy) begin
      host_we   = 1'b1;
      host_addr = 4'd3;
      host_data = 8'hAA;
      @(negedge clk);
      host_we = 1'b0;
    end

    for (int b = 0; b < 16; b++) begin
      if (b == v.done_after && !v.coincide) break;
      cpu_ready = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_byte_avail", idx), 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        check($sformatf("v%0d_byte%0d", idx, b), 32'(prog_data), 32'(exp_b));
      end
      if (b == v.rst_at) begin
        rst       = 1'b1;
        cpu_ready = 1'b0;
        @(negedge clk);
        rst     = 1'b0;
        aborted = 1'b1;
        check($sformatf("v%0d_rst_prog_data", idx), 32'(prog_data), 32'd0);
        break;
      end
      if (b == 15 && v.coincide) begin
        cpu_ready     = 1'b0;
        cpu_done_load = 1'b1;
        @(negedge clk);
        cpu_done_load = 1'b0;
        done_sent     = 1'b1;
        break;
      end
      cpu_ready = 1'b0;
      repeat (3) @(negedge clk);
    end

    if (!aborted && !done_sent) begin
      if (v.done_after >= 16) begin
        check($sformatf("v%0d_wait_cnt", idx), 32'(byte_cnt), 32'd16);
        check($sformatf("v%0d_wait_programming", idx), 32'(programming), 32'd1);
      end
      cpu_done_load = 1'b1;
      @(negedge clk);
      cpu_done_load = 1'b0;
    end

    check($sformatf("v%0d_load_done", idx), 32'(load_done), 32'(v.exp_done));
    check($sformatf("v%0d_error", idx), 32'(error), 32'(v.exp_err));
    check($sformatf("v%0d_byte_cnt", idx), 32'(byte_cnt), 32'(v.exp_cnt));
    check($sformatf("v%0d_programming", idx), 32'(programming), 32'd0);
    check($sformatf("v%0d_busy", idx), 32'(busy), 32'd0);
    check($sformatf("v%0d_queue_drained", idx), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cycles;
    //          base   step   done coin rst wrb wrs  done err cnt
    vecs[0] = '{8'h00, 8'h01, 16,  0,   16, 0,  0,   1,   0,  16};
    vecs[1] = '{8'h30, 8'h03, 5,   0,   16, 0,  0,   0,   1,  5};
    vecs[2] = '{8'h80, 8'h05, 16,  0,   7,  0,  0,   0,   0,  0};
    vecs[3] = '{8'h80, 8'h05, 16,  0,   16, 0,  0,   1,   0,  16};
    vecs[4] = '{8'h10, 8'h01, 16,  0,   16, 1,  0,   1,   0,  16};
    vecs[5] = '{8'hC0, 8'h09, 16,  1,   16, 0,  0,   1,   0,  16};
    vecs[6] = '{8'h55, 8'h02, 0,   0,   16, 0,  0,   0,   1,  0};
    vecs[7] = '{8'h01, 8'h11, 15,  0,   16, 0,  0,   0,   1,  15};
    vecs[8] = '{8'hE0, 8'h01, 16,  0,   16, 0,  1,   1,   0,  16};

    rst           = 1'b1;
    host_we       = 1'b0;
    host_addr     = '0;
    host_data     = '0;
    start         = 1'b0;
    cpu_ready     = 1'b0;
    cpu_done_load = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_programming", 32'(programming), 32'd0);
    check("reset_prog_data", 32'(prog_data), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_load_done", 32'(load_done), 32'd0);
    check("reset_error", 32'(error), 32'd0);
    check("reset_byte_cnt", 32'(byte_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Handshake inputs outside a load must not disturb DONE.
    cpu_ready     = 1'b1;
    cpu_done_load = 1'b1;
    repeat (3) @(negedge clk);
    cpu_ready     = 1'b0;
    cpu_done_load = 1'b0;
    @(negedge clk);
    check("idle_ignore_load_done", 32'(load_done), 32'd1);
    check("idle_ignore_busy", 32'(busy), 32'd0);
    check("idle_ignore_byte_cnt", 32'(byte_cnt), 32'd16);

    // CPU never raises ready.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("stall_armed", 32'(busy), 32'd1);
`ifdef LOADER_TIMEOUT_EN
    cycles = 0;
    while (!error && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check("timeout_cycles", 32'(cycles), 32'd20);
    check("timeout_programming", 32'(programming), 32'd0);
`else
    cycles = 0;
    repeat (1000) begin
      @(negedge clk);
      cycles++;
    end
    check("no_timeout_busy", 32'(busy), 32'd1);
    check("no_timeout_programming", 32'(programming), 32'd1);
    check("no_timeout_error", 32'(error), 32'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("final_reset_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
